// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register word map, FSM states, null ID.
package irq_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;

    localparam int ID_NONE = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Data-memory bus slice seen by the interrupt controller: CPU is master, controller is slave.
interface irq_controller_if;
    logic [3:0]  I_addr;
    logic        I_we;
    logic        I_re;
    logic [31:0] I_wdata;
    logic [31:0] O_rdata;

    modport master (output I_addr, output I_we, output I_re, output I_wdata, input O_rdata);
    modport slave  (input I_addr, input I_we, input I_re, input I_wdata, output O_rdata);
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines.
// With IRQ_EDGE_EN defined a third flop provides a one-cycle rising-edge strobe.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync
`ifdef IRQ_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise
`endif
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign sync = sync_reg;

`ifdef IRQ_EDGE_EN
    logic [WIDTH-1:0] prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_reg <= '0;
        else     prev_reg <= sync_reg;
    end

    assign rise = sync_reg & ~prev_reg;
`endif

endmodule

// File: rtl/irq_controller.sv
// Platform interrupt controller: pending/enable registers, claim/complete handshake, one IRQ line.
// Define IRQ_EDGE_EN for edge-latched pending bits; default is level mode.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic [NUM_SRC-1:0]  I_src,
    irq_controller_if.slave     bus,
    output logic                O_interrupt
);

    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] active;
    logic [ID_W-1:0]    in_service_id_reg;
    logic [ID_W-1:0]    claim_id, claim_ret;
    irq_state_t         state_reg, state_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic               interrupt_reg;
    logic [1:0]         reg_sel;
    logic               rd_en, claim_rd, complete_wr;
    logic               unused_bits;

`ifdef IRQ_EDGE_EN
    logic [NUM_SRC-1:0] rise;
    irq_sync #(.WIDTH(NUM_SRC)) u_sync (
        .clk(I_clk), .rst(I_rst), .din(I_src), .sync(sync2), .rise(rise)
    );
`else
    irq_sync #(.WIDTH(NUM_SRC)) u_sync (
        .clk(I_clk), .rst(I_rst), .din(I_src), .sync(sync2)
    );
`endif

    assign reg_sel = bus.I_addr[3:2];
    // A simultaneous write wins; the read half of the cycle is dropped entirely.
    assign rd_en   = bus.I_re & ~bus.I_we;
    assign active  = pending_reg & enable_reg;

    always_comb begin
        claim_id = ID_W'(ID_NONE);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) claim_id = ID_W'(i + 1);
        end
    end

    assign claim_ret   = (state_reg == IDLE) ? ID_W'(ID_NONE) : claim_id;
    assign claim_rd    = rd_en && (reg_sel == REG_CLAIM) && (claim_ret != ID_W'(ID_NONE));
    assign complete_wr = bus.I_we && (reg_sel == REG_CLAIM) && (state_reg == SERVICE)
                      && (bus.I_wdata[ID_W-1:0] == in_service_id_reg);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
`ifdef IRQ_EDGE_EN
        logic claim_clear;
        assign claim_clear      = claim_rd && (claim_ret == ID_W'(gi + 1));
        assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~claim_clear);
`else
        // in_service_id is cleared on completion, so this mask is empty outside SERVICE.
        logic in_service;
        assign in_service       = (in_service_id_reg == ID_W'(gi + 1));
        assign pending_next[gi] = sync2[gi] & ~in_service;
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|active) state_next = REQ;
            REQ: begin
                if (claim_rd)      state_next = SERVICE;
                else if (~|active) state_next = IDLE;
            end
            SERVICE: if (complete_wr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdata_next = '0;
        case (reg_sel)
            REG_PENDING: rdata_next = 32'(pending_reg);
            REG_ENABLE:  rdata_next = 32'(enable_reg);
            REG_CLAIM:   rdata_next = 32'(claim_ret);
            default:     rdata_next = '0;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            pending_reg       <= '0;
            enable_reg        <= '0;
            in_service_id_reg <= '0;
            rdata_reg         <= '0;
            interrupt_reg     <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            interrupt_reg <= (state_reg == REQ) | (state_next == REQ);
            if (bus.I_we && (reg_sel == REG_ENABLE))
                enable_reg <= bus.I_wdata[NUM_SRC-1:0];
            if ((state_reg == REQ) && claim_rd)
                in_service_id_reg <= claim_ret;
            else if (complete_wr)
                in_service_id_reg <= '0;
            if (rd_en)
                rdata_reg <= rdata_next;
        end
    end

    assign bus.O_rdata = rdata_reg;
    assign O_interrupt = interrupt_reg;

    assign unused_bits = ^{bus.I_addr[1:0], bus.I_wdata
`ifdef IRQ_EDGE_EN
                           , sync2
`endif
                          };

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, handshake corner cases, random model check.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src = '0;
    logic       interrupt;

    irq_controller_if bus();

    irq_controller #(.NUM_SRC(8), .ID_W(5)) dut (
        .I_clk(clk), .I_rst(rst), .I_src(src), .bus(bus), .O_interrupt(interrupt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        bus.I_addr  = addr;
        bus.I_wdata = data;
        bus.I_we    = 1'b1;
        tick();
        bus.I_we    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        bus.I_addr = addr;
        bus.I_re   = 1'b1;
        tick();
        bus.I_re   = 1'b0;
        data       = bus.O_rdata;
    endtask

    // Clears whatever is still latched so each scenario starts from an empty controller.
    task automatic drain();
        logic [31:0] id;
        wr(4'h4, 32'hFF);
        repeat (12) begin
            tick();
            tick();
            rd(4'h8, id);
            if (id != 0) wr(4'h8, id);
        end
        wr(4'h4, 32'h0);
        tick();
    endtask

    function automatic int lowest_id(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    initial begin
        logic [31:0] d;
        logic [7:0]  r_src, r_en, exp_pend;
        int          in_svc, exp_claim, cid, second_id;

        bus.I_addr = '0; bus.I_we = 1'b0; bus.I_re = 1'b0; bus.I_wdata = '0;

        // Reset state
        tick(); tick();
        check("reset_irq", {31'b0, interrupt}, 32'h0);
        check("reset_rdata", bus.O_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Register map table
        tbl[0]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{1'b0, 4'h4, 32'h0,         32'hFF};
        tbl[2]  = '{1'b1, 4'h4, 32'h1234_5A5A, 32'h0};
        tbl[3]  = '{1'b0, 4'h4, 32'h0,         32'h5A};
        tbl[4]  = '{1'b0, 4'h5, 32'h0,         32'h5A};
        tbl[5]  = '{1'b1, 4'hC, 32'hFFFF,      32'h0};
        tbl[6]  = '{1'b0, 4'hC, 32'h0,         32'h0};
        tbl[7]  = '{1'b0, 4'h7, 32'h0,         32'h5A};
        tbl[8]  = '{1'b0, 4'h0, 32'h0,         32'h0};
        tbl[9]  = '{1'b0, 4'h6, 32'h0,         32'h5A};
        tbl[10] = '{1'b0, 4'h8, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 4'h4, 32'h0,         32'h0};
        tbl[12] = '{1'b0, 4'h4, 32'h0,         32'h0};
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
            else begin
                rd(tbl[i].addr, d);
                check($sformatf("table[%0d] addr %0h", i, tbl[i].addr), d, tbl[i].exp);
            end
        end

        // Simultaneous write and read: write lands, rdata holds
        wr(4'h4, 32'h5A);
        rd(4'h4, d);
        check("we_re_pre", d, 32'h5A);
        bus.I_addr = 4'h4; bus.I_wdata = 32'h3C; bus.I_we = 1'b1; bus.I_re = 1'b1;
        tick();
        bus.I_we = 1'b0; bus.I_re = 1'b0;
        check("we_re_rdata_held", bus.O_rdata, 32'h5A);
        rd(4'h4, d);
        check("we_re_write_done", d, 32'h3C);
        wr(4'h4, 32'h0);

        // Basic handshake with 4-edge latency
        wr(4'h4, 32'h04);
        src[2] = 1'b1;
        tick(); tick(); tick();
        check("hs_irq_edge3", {31'b0, interrupt}, 32'h0);
        tick();
        check("hs_irq_edge4", {31'b0, interrupt}, 32'h1);
        rd(4'h8, d);
        check("hs_claim", d, 32'h3);
        tick();
        check("hs_irq_drop", {31'b0, interrupt}, 32'h0);
        tick(); tick(); tick();
        check("hs_irq_in_service", {31'b0, interrupt}, 32'h0);
`ifndef IRQ_EDGE_EN
        rd(4'h0, d);
        check("hs_pending_masked", d, 32'h0);
`endif
        wr(4'h8, 32'h3);
        check("hs_cmp_edge0", {31'b0, interrupt}, 32'h0);
        tick();
        check("hs_cmp_edge1", {31'b0, interrupt}, 32'h0);
        tick();
`ifndef IRQ_EDGE_EN
        check("hs_reassert", {31'b0, interrupt}, 32'h1);
`else
        check("hs_no_reassert", {31'b0, interrupt}, 32'h0);
`endif
        src = '0;
        repeat (6) tick();
        drain();

        // Priority
        wr(4'h4, 32'hFF);
        src = 8'h22;
        repeat (5) tick();
        check("pri_irq", {31'b0, interrupt}, 32'h1);
        rd(4'h8, d);
        check("pri_claim_first", d, 32'h2);
`ifndef IRQ_EDGE_EN
        tick();
        rd(4'h8, d);
        check("pri_claim_in_service", d, 32'h6);
        tick();
        check("pri_no_nesting", {31'b0, interrupt}, 32'h0);
`endif
        wr(4'h8, 32'h2);
        src[1] = 1'b0;
        repeat (5) tick();
        check("pri_irq_again", {31'b0, interrupt}, 32'h1);
        rd(4'h8, d);
        check("pri_claim_second", d, 32'h6);
        wr(4'h8, 32'h6);
        src = '0;
        repeat (6) tick();
        drain();

        // Masking
        src = 8'hFF;
        repeat (5) tick();
        rd(4'h0, d);
        check("mask_pending", d, 32'hFF);
        check("mask_irq_low", {31'b0, interrupt}, 32'h0);
        rd(4'h8, d);
        check("mask_claim_none", d, 32'h0);
        wr(4'h4, 32'h80);
        tick();
        check("mask_irq_high", {31'b0, interrupt}, 32'h1);
        rd(4'h8, d);
        check("mask_claim8", d, 32'h8);
        src = '0;
        repeat (5) tick();
        wr(4'h8, 32'h8);
        repeat (4) tick();
        drain();

        // Bad complete: ID 4 waiting while ID 3 is in service
        wr(4'h4, 32'h0C);
        src = 8'h0C;
        repeat (5) tick();
        rd(4'h8, d);
        check("bad_claim", d, 32'h3);
        wr(4'h8, 32'h4);
        repeat (3) tick();
        check("bad_cmp_ignored", {31'b0, interrupt}, 32'h0);
        wr(4'h8, 32'h3);
        tick(); tick();
        check("good_cmp_reraise", {31'b0, interrupt}, 32'h1);
`ifndef IRQ_EDGE_EN
        second_id = 3;
`else
        second_id = 4;
`endif
        rd(4'h8, d);
        check("good_cmp_next_claim", d, 32'(second_id));
        src = '0;
        repeat (5) tick();
        wr(4'h8, 32'(second_id));
        repeat (4) tick();
        drain();

`ifdef IRQ_EDGE_EN
        // Edge mode: pulses latch, claim clears, pulse during service re-raises
        wr(4'h4, 32'h01);
        src[0] = 1'b1; tick(); src[0] = 1'b0;
        repeat (6) tick();
        rd(4'h0, d);
        check("edge_pending_held", d, 32'h1);
        check("edge_irq", {31'b0, interrupt}, 32'h1);
        rd(4'h8, d);
        check("edge_claim", d, 32'h1);
        rd(4'h0, d);
        check("edge_pending_cleared", d, 32'h0);
        src[0] = 1'b1; tick(); src[0] = 1'b0;
        repeat (6) tick();
        check("edge_irq_in_service", {31'b0, interrupt}, 32'h0);
        wr(4'h8, 32'h1);
        tick(); tick();
        check("edge_reraise", {31'b0, interrupt}, 32'h1);
        drain();
`endif

        // Reset while a request is outstanding
        wr(4'h4, 32'h01);
        src[0] = 1'b1;
        repeat (5) tick();
        check("rst_pre_irq", {31'b0, interrupt}, 32'h1);
        rd(4'h4, d);
        check("rst_pre_rdata", d, 32'h1);
        src = '0;
        rst = 1'b1;
        #1;
        check("rst_irq_async", {31'b0, interrupt}, 32'h0);
        check("rst_rdata_async", bus.O_rdata, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        rd(4'h4, d);
        check("rst_enable", d, 32'h0);
        rd(4'h0, d);
        check("rst_pending", d, 32'h0);

`ifndef IRQ_EDGE_EN
        // Random level-mode traffic against a steady-state model
        in_svc = 0;
        for (int it = 0; it < 40; it++) begin
            r_src = 8'($urandom_range(0, 255));
            r_en  = 8'($urandom_range(0, 255));
            wr(4'h4, 32'(r_en));
            src = r_src;
            repeat (5) tick();
            exp_pend = r_src;
            if (in_svc != 0) exp_pend[in_svc-1] = 1'b0;
            check($sformatf("rnd%0d_irq", it), {31'b0, interrupt},
                  32'((in_svc == 0) && ((exp_pend & r_en) != 0)));
            rd(4'h0, d);
            check($sformatf("rnd%0d_pending", it), d, 32'(exp_pend));
            exp_claim = lowest_id(exp_pend & r_en);
            rd(4'h8, d);
            check($sformatf("rnd%0d_claim", it), d, 32'(exp_claim));
            if (in_svc == 0 && exp_claim != 0) in_svc = exp_claim;
            if ($urandom_range(0, 1) == 1) begin
                cid = ($urandom_range(0, 1) == 1) ? in_svc : int'($urandom_range(0, 8));
                wr(4'h8, 32'(cid));
                if (in_svc != 0 && cid == in_svc) in_svc = 0;
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
